fix_ari_div: RTL
================

Name: fix_ari_div

Overview:
- Iterative fixed-point divider; the inverse operation of the team's fixed-point multiplier.
- Operands and result use the same sign-magnitude format: 1 sign bit, INTE integer bits, POIN fraction bits (Q6.8 by default).
- Computes one quotient bit per cycle (restoring algorithm) under a start/busy/done handshake.
- Feeds datapath blocks that need a ratio or normalisation and can tolerate multi-cycle latency.

Parameters:
- DATA, 15: total operand and result width (sign plus magnitude).
- INTE, 6: integer bits of the magnitude.
- POIN, 8: fraction bits of the magnitude. INTE+POIN must equal DATA-1.
- EX_SI, DATA-1: magnitude width; derived, not overridden.
- NUM_W, EX_SI+POIN: width of the scaled numerator and number of iterations; derived.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- data_in1  input  DATA  dividend, sign-magnitude; bit DATA-1 is the sign.
- data_in2  input  DATA  divisor, sign-magnitude.
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  one-cycle pulse; data_out, ovf and dz are valid from this cycle.
- data_out  output  DATA  quotient, sign-magnitude, same Q format as the inputs.
- ovf  output  1  quotient magnitude saturated.
- dz  output  1  divisor magnitude was zero.

Behaviour:
- Reset: synchronous and active-high. It takes priority over everything, including an operation in progress. It forces state to IDLE and sets busy, done, data_out, ovf, dz, the counter and all internal registers to 0. An aborted operation never produces a done.
- States:
  - IDLE: start=1 latches the operands. If the divisor magnitude is 0, go to DONE. Otherwise go to CALC with the remainder cleared, the numerator register loaded with {magnitude(data_in1), POIN zeros}, and the counter set to NUM_W-1.
  - CALC: busy=1. Each cycle:
    - shift the next numerator MSB into the remainder (EX_SI+1 bits wide);
    - if remainder is at least the divisor magnitude, subtract it and shift in quotient bit 1, else shift in 0;
    - when the counter reaches 0, go to DONE; otherwise decrement the counter.
    - The quotient register is NUM_W bits.
  - DONE: done=1 for exactly one cycle. data_out, ovf and dz are registered on entry and go to IDLE next. These outputs hold until the next done or reset. busy=0.
- Latency: start accepted at cycle 0 gives done at cycle NUM_W+1 (23 by default). Divide-by-zero gives done at cycle 1.
- start is ignored while in CALC or DONE. A back-to-back start is accepted in the cycle after done.
- Operands are latched at accept; input changes afterwards have no effect.
- Result rules:
  - Quotient magnitude is the truncated (toward zero) value of (|a|<<POIN)/|b|.
  - If the quotient needs more than EX_SI bits, the magnitude saturates to all ones and ovf=1.
  - Divide by zero: magnitude is all ones, dz=1, ovf=0.
  - Sign is the XOR of the operand signs, except a zero magnitude forces sign 0 (no negative zero). A -0 input is treated as 0.
- No combinational path from inputs to outputs.

Test Plan:
- Basic: 3.0/2.0, i.e. data_in1=15'h0300, data_in2=15'h0200, start for 1 cycle -> done at cycle 23; data_out=15'h0180, ovf=0, dz=0; busy high for cycles 1-22.
- Signs and truncation: -7.5/2.5 (15'h4780, 15'h0280) -> 15'h4300. 1.0/3.0 (15'h0100, 15'h0300) -> 15'h0055. -0.0039/64-range divisor (15'h4001, 15'h3FFF) -> 15'h0000, sign cleared.
- Saturation: 15'h3FFF / 15'h0001 -> data_out=15'h3FFF, ovf=1. Same with data_in1 sign set -> 15'h7FFF, ovf=1.
- Divide by zero: 15'h0100 / 15'h4000 -> done at cycle 1, data_out=15'h7FFF, dz=1, ovf=0.
- Handshake: start pulses every cycle during CALC with changing operands -> only the first operation completes, with the correct result. A start in the cycle after done is accepted, and its done arrives 23 cycles later.
- Reset mid-op: assert rst at cycle 10 of CALC -> next edge gives busy=0 and all outputs 0, no done pulse. A new start after reset release gives the correct result.

Source files
------------

// File: rtl/fix_ari_div.sv
// fix_ari_div: iterative restoring divider for sign-magnitude fixed-point operands
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : request, sampled only while idle
//   data_in1/data_in2 : dividend/divisor, sign in bit DATA-1, Q(INTE).(POIN) magnitude
//   busy              : operation in progress
//   done              : one-cycle pulse, results valid from this cycle and held
//   data_out/ovf/dz   : quotient, saturation flag, divide-by-zero flag
module fix_ari_div #(
   parameter int DATA = 15,
   parameter int INTE = 6,
   parameter int POIN = 8,
   localparam int EX_SI = INTE + POIN,
   localparam int NUM_W = EX_SI + POIN,
   localparam int CW = $clog2(NUM_W)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DATA-1:0] data_in1,
   input  logic [DATA-1:0] data_in2,
   output logic            busy,
   output logic            done,
   output logic [DATA-1:0] data_out,
   output logic            ovf,
   output logic            dz
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_q, state_d;
   logic [EX_SI-1:0] div_q, div_d, mag_a, mag_b, mag_r;
   logic [NUM_W-1:0] num_q, num_d, quo_q, quo_d, quo_nx;
   logic [EX_SI:0] rem_q, rem_d, rem_sh;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DATA-1:0] out_q, out_d;
   logic sign_q, sign_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;
   logic ge, sat, sgn_in;
   always_comb begin
      mag_a = data_in1[EX_SI-1:0];
      mag_b = data_in2[EX_SI-1:0];
      sgn_in = data_in1[DATA-1] ^ data_in2[DATA-1];
      // the remainder never exceeds the divisor, so its top bit drops out of the shift
      rem_sh = (EX_SI+1)'({rem_q, num_q[NUM_W-1]});
      ge = rem_sh >= {1'b0, div_q};
      quo_nx = NUM_W'({quo_q, ge});
      // any quotient bit above the magnitude width means the result does not fit
      sat = |quo_nx[NUM_W-1:EX_SI];
      mag_r = sat ? '1 : quo_nx[EX_SI-1:0];
      state_d = state_q;
      div_d = div_q;
      num_d = num_q;
      quo_d = quo_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      sign_d = sign_q;
      busy_d = busy_q;
      done_d = 1'b0;
      out_d = out_q;
      ovf_d = ovf_q;
      dz_d = dz_q;
      case (state_q)
         IDLE: if (start) begin
            sign_d = sgn_in;
            div_d = mag_b;
            if (mag_b == '0) begin
               state_d = DONE;
               done_d = 1'b1;
               out_d = {sgn_in, {EX_SI{1'b1}}};
               ovf_d = 1'b0;
               dz_d = 1'b1;
            end else begin
               state_d = CALC;
               busy_d = 1'b1;
               rem_d = '0;
               num_d = {mag_a, {POIN{1'b0}}};
               quo_d = '0;
               cnt_d = CW'(NUM_W - 1);
            end
         end
         CALC: begin
            rem_d = ge ? rem_sh - {1'b0, div_q} : rem_sh;
            quo_d = quo_nx;
            num_d = num_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
               busy_d = 1'b0;
               done_d = 1'b1;
               out_d = {sign_q & (|mag_r), mag_r};
               ovf_d = sat;
               dz_d = 1'b0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q <= '0;
         num_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         sign_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         out_q <= '0;
         ovf_q <= 1'b0;
         dz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q <= div_d;
         num_q <= num_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
         sign_q <= sign_d;
         busy_q <= busy_d;
         done_q <= done_d;
         out_q <= out_d;
         ovf_q <= ovf_d;
         dz_q <= dz_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign data_out = out_q;
   assign ovf = ovf_q;
   assign dz = dz_q;
endmodule
